// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared types and constants for decode-stage
// branch hazard sequencing.
package branch_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    BHC_IDLE    = 2'd0,
    BHC_STALL   = 2'd1,
    BHC_RESOLVE = 2'd2
  } bhc_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic logic reg_hit(
    input logic [4:0] dst,
    input logic [4:0] src
  );
    return (dst == src) && (src != REG_ZERO);
  endfunction

endpackage

// File: rtl/branch_hazard_ctrl_if.sv
// Decode/EX/MEM view into the branch hazard
// controller and its stall/flush/perf results.
interface branch_hazard_ctrl_if #(
  parameter int PERF_WIDTH = 16
);
  logic                  ext_stall;
  logic                  id_branch;
  logic                  id_jump_reg;
  logic                  id_rt_is_zero;
  logic [4:0]            id_rs;
  logic [4:0]            id_rt;
  logic                  id_pc_src;
  logic                  ex_reg_write;
  logic [4:0]            ex_write_reg;
  logic                  mem_reg_write;
  logic                  mem_mem_to_reg;
  logic [4:0]            mem_write_reg;
  logic                  perf_clear;
  logic                  stall_fetch;
  logic                  stall_decode;
  logic                  flush_execute;
  logic                  flush_decode;
  logic                  fwd_rs;
  logic                  fwd_rt;
  logic [PERF_WIDTH-1:0] taken_cnt;
  logic [PERF_WIDTH-1:0] not_taken_cnt;
  logic [PERF_WIDTH-1:0] stall_cnt;
  logic                  stall_err;

  modport master (
    output ext_stall, id_branch, id_jump_reg,
    output id_rt_is_zero, id_rs, id_rt, id_pc_src,
    output ex_reg_write, ex_write_reg,
    output mem_reg_write, mem_mem_to_reg,
    output mem_write_reg, perf_clear,
    input  stall_fetch, stall_decode,
    input  flush_execute, flush_decode,
    input  fwd_rs, fwd_rt,
    input  taken_cnt, not_taken_cnt,
    input  stall_cnt, stall_err
  );

  modport slave (
    input  ext_stall, id_branch, id_jump_reg,
    input  id_rt_is_zero, id_rs, id_rt, id_pc_src,
    input  ex_reg_write, ex_write_reg,
    input  mem_reg_write, mem_mem_to_reg,
    input  mem_write_reg, perf_clear,
    output stall_fetch, stall_decode,
    output flush_execute, flush_decode,
    output fwd_rs, fwd_rt,
    output taken_cnt, not_taken_cnt,
    output stall_cnt, stall_err
  );
endinterface

// File: rtl/branch_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous
// clear taking priority over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Decode-stage branch/JR hazard stall, comparator
// forwarding, taken-branch squash and perf counters.
module branch_hazard_ctrl
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int PERF_WIDTH = 16,
  parameter int MAX_STALL  = 3,
  parameter int DELAY_SLOT = 0
) (
  input logic clock,
  input logic reset_n,
  branch_hazard_ctrl_if.slave bus
);

  localparam int RUN_CL = $clog2(MAX_STALL + 2);
  localparam int RUN_W  = (RUN_CL < 2) ? 2 : RUN_CL;
  localparam logic [RUN_W-1:0] RUN_TOP =
    RUN_W'(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_ARM =
    RUN_W'(MAX_STALL);
  localparam logic NO_SLOT = (DELAY_SLOT == 0);

  bhc_state_e       state;
  logic [RUN_W-1:0] run;

  logic ctl;
  logic use_rt;
  logic ex_rs, ex_rt;
  logic mem_rs, mem_rt;
  logic alu_rs, alu_rt;
  logic haz_ex;
  logic haz_mem;
  logic hazard;
  logic resolve;
  logic live;

  assign ctl    = bus.id_branch | bus.id_jump_reg;
  assign use_rt = bus.id_branch & ~bus.id_rt_is_zero;

  assign ex_rs  = reg_hit(bus.ex_write_reg, bus.id_rs);
  assign ex_rt  = reg_hit(bus.ex_write_reg, bus.id_rt);
  assign mem_rs = reg_hit(bus.mem_write_reg, bus.id_rs);
  assign mem_rt = reg_hit(bus.mem_write_reg, bus.id_rt);

  assign haz_ex = ctl & bus.ex_reg_write &
                  (ex_rs | (use_rt & ex_rt));
  assign haz_mem = ctl & bus.mem_reg_write &
                   bus.mem_mem_to_reg &
                   (mem_rs | (use_rt & mem_rt));
  assign hazard  = haz_ex | haz_mem;
  assign resolve = ctl & ~hazard & ~bus.ext_stall;

  // Combinational outputs are gated while in reset.
  assign live = reset_n;

  assign alu_rs = ctl & bus.mem_reg_write &
                  ~bus.mem_mem_to_reg & mem_rs;
  assign alu_rt = alu_rs & 1'b0 | (ctl & use_rt &
                  bus.mem_reg_write &
                  ~bus.mem_mem_to_reg & mem_rt);

  assign bus.stall_fetch   = live & hazard;
  assign bus.stall_decode  = live & hazard;
  assign bus.flush_execute = live & hazard;
  assign bus.fwd_rs = live & alu_rs & ~haz_ex;
  assign bus.fwd_rt = live & alu_rt & ~haz_ex;
  assign bus.flush_decode = live & resolve &
                            bus.id_pc_src & NO_SLOT;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= BHC_IDLE;
      run           <= '0;
      bus.stall_err <= 1'b0;
    end else begin
      if (!bus.ext_stall) begin
        unique case (state)
          BHC_IDLE:
            state <= hazard ? BHC_STALL : BHC_IDLE;
          BHC_STALL:
            state <= hazard ? BHC_STALL : BHC_RESOLVE;
          BHC_RESOLVE:
            state <= hazard ? BHC_STALL : BHC_IDLE;
          default:
            state <= BHC_IDLE;
        endcase
        if (hazard) begin
          if (run != RUN_TOP) run <= run + 1'b1;
        end else begin
          run <= '0;
        end
      end
      if (bus.perf_clear) begin
        bus.stall_err <= 1'b0;
      end else if (!bus.ext_stall && hazard &&
                   run == RUN_ARM) begin
        bus.stall_err <= 1'b1;
      end
    end
  end

  sat_counter #(.WIDTH(PERF_WIDTH)) u_taken (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (bus.perf_clear),
    .inc     (resolve & bus.id_pc_src),
    .count   (bus.taken_cnt)
  );

  sat_counter #(.WIDTH(PERF_WIDTH)) u_not_taken (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (bus.perf_clear),
    .inc     (resolve & ~bus.id_pc_src),
    .count   (bus.not_taken_cnt)
  );

  sat_counter #(.WIDTH(PERF_WIDTH)) u_stall (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (bus.perf_clear),
    .inc     (hazard & ~bus.ext_stall),
    .count   (bus.stall_cnt)
  );

endmodule
